// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared types and constants for the register-bus arbiter.
package rggen_bus_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_SLVERR  = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    // Index width that stays legal for a single requester.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rggen_mux.sv
// One-hot AND-OR multiplexer; an all-zero select yields zero.
module rggen_mux #(
    parameter int WIDTH   = 1,
    parameter int ENTRIES = 2
) (
    input  logic [ENTRIES-1:0]       i_select,
    input  logic [ENTRIES*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]         o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            o_data |= i_data[k*WIDTH+:WIDTH] & {WIDTH{i_select[k]}};
        end
    end

endmodule

// File: rtl/rggen_rr_picker.sv
// Round-robin picker: first requester strictly after last_grant, circularly.
module rggen_rr_picker
    import rggen_bus_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 2,
    localparam int IW        = index_width(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] i_request,
    input  logic [IW-1:0]         i_last_grant,
    output logic [REQUESTERS-1:0] o_grant
);

    logic [2*REQUESTERS-1:0] doubled;
    logic                    found;

    // Searching the doubled vector over (last, last+N] walks the ring once
    // without any variable-width rotate.
    always_comb begin
        doubled = {i_request, i_request};
        o_grant = '0;
        found   = 1'b0;
        for (int j = 0; j < 2 * REQUESTERS; j++) begin
            if (!found && doubled[j] && (j > int'(i_last_grant)) &&
                (j <= int'(i_last_grant) + REQUESTERS)) begin
                found = 1'b1;
                o_grant[(j >= REQUESTERS) ? (j - REQUESTERS) : j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register-bus port between REQUESTERS masters.
// Optional BUSY timeout: define RGGEN_BUS_ARBITER_TIMEOUT_EN.
module rggen_bus_arbiter
    import rggen_bus_arbiter_pkg::*;
#(
    parameter int REQUESTERS     = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [REQUESTERS-1:0]              i_request,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS-1:0]              i_write,
    input  logic [REQUESTERS*DATA_WIDTH-1:0]   i_write_data,
    output logic [REQUESTERS-1:0]              o_ready,
    output logic [DATA_WIDTH-1:0]              o_read_data,
    output logic [1:0]                         o_status,
    output logic                               o_bus_valid,
    output logic [ADDRESS_WIDTH-1:0]           o_bus_address,
    output logic                               o_bus_write,
    output logic [DATA_WIDTH-1:0]              o_bus_write_data,
    input  logic                               i_bus_ready,
    input  logic [DATA_WIDTH-1:0]              i_bus_read_data,
    input  logic [1:0]                         i_bus_status
);

    localparam int IW = index_width(REQUESTERS);

    state_e                state;
    logic [REQUESTERS-1:0] grant;
    logic [REQUESTERS-1:0] next_grant;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         grant_index;
    logic                  bus_done;
    logic                  timeout;
    logic                  done;

    rggen_rr_picker #(.REQUESTERS(REQUESTERS)) u_picker (
        .i_request    (i_request),
        .i_last_grant (last_grant),
        .o_grant      (next_grant)
    );

    rggen_mux #(.WIDTH(ADDRESS_WIDTH), .ENTRIES(REQUESTERS)) u_mux_address (
        .i_select (grant),
        .i_data   (i_address),
        .o_data   (o_bus_address)
    );

    rggen_mux #(.WIDTH(1), .ENTRIES(REQUESTERS)) u_mux_write (
        .i_select (grant),
        .i_data   (i_write),
        .o_data   (o_bus_write)
    );

    rggen_mux #(.WIDTH(DATA_WIDTH), .ENTRIES(REQUESTERS)) u_mux_write_data (
        .i_select (grant),
        .i_data   (i_write_data),
        .o_data   (o_bus_write_data)
    );

    always_comb begin
        grant_index = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (grant[k]) grant_index = IW'(k);
        end
    end

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] busy_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || state == IDLE) begin
            busy_count <= '0;
        end else if (!i_bus_ready && busy_count != CW'(TIMEOUT_CYCLES)) begin
            busy_count <= busy_count + 1'b1;
        end
    end

    // A real response in the expiry cycle takes precedence.
    assign timeout = (state == BUSY) && !i_bus_ready && (busy_count == CW'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    assign bus_done    = (state == BUSY) && i_bus_ready;
    assign done        = bus_done || timeout;
    assign o_bus_valid = (state == BUSY);
    assign o_ready     = done ? grant : '0;
    assign o_read_data = bus_done ? i_bus_read_data : '0;
    assign o_status    = bus_done ? i_bus_status : (timeout ? STATUS_TIMEOUT : STATUS_OK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(REQUESTERS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|i_request) begin
                        grant <= next_grant;
                        state <= BUSY;
                    end else begin
                        grant <= '0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state      <= IDLE;
                        last_grant <= grant_index;
                        grant      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter (3 requesters, timeout scenario when compiled in).
module tb_rggen_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      i_request;
    logic [N*AW-1:0]   i_address;
    logic [N-1:0]      i_write;
    logic [N*DW-1:0]   i_write_data;
    logic [N-1:0]      o_ready;
    logic [DW-1:0]     o_read_data;
    logic [1:0]        o_status;
    logic              o_bus_valid;
    logic [AW-1:0]     o_bus_address;
    logic              o_bus_write;
    logic [DW-1:0]     o_bus_write_data;
    logic              i_bus_ready;
    logic [DW-1:0]     i_bus_read_data;
    logic [1:0]        i_bus_status;

    int errors = 0;
    int checks = 0;

    rggen_bus_arbiter #(
        .REQUESTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_request(i_request), .i_address(i_address),
        .i_write(i_write), .i_write_data(i_write_data), .o_ready(o_ready),
        .o_read_data(o_read_data), .o_status(o_status), .o_bus_valid(o_bus_valid),
        .o_bus_address(o_bus_address), .o_bus_write(o_bus_write),
        .o_bus_write_data(o_bus_write_data), .i_bus_ready(i_bus_ready),
        .i_bus_read_data(i_bus_read_data), .i_bus_status(i_bus_status)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_request = '0; i_address = '0; i_write = '0; i_write_data = '0;
        i_bus_ready = 1'b0; i_bus_read_data = '0; i_bus_status = 2'b00;
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        i_rst = 1'b1;
        i_request = 3'b111;
        i_bus_ready = 1'b1;
        i_bus_read_data = 32'hCAFE0000;
        i_bus_status = 2'b01;
        step();
        step();
        checks++; if (o_bus_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_bus_valid); end
        checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", o_ready); end
        checks++; if (o_bus_address !== 8'h00 || o_bus_write !== 1'b0 || o_bus_write_data !== 32'h0)
            begin errors++; $display("FAIL reset_payload: got %h/%b/%h want 0", o_bus_address, o_bus_write, o_bus_write_data); end
        checks++; if (o_read_data !== 32'h0 || o_status !== 2'b00)
            begin errors++; $display("FAIL reset_resp: got %h/%b want 0/00", o_read_data, o_status); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        i_request = 3'b001;
        i_address[0*AW+:AW] = 8'h10;
        i_write[0] = 1'b0;
        #1;
        checks++; if (o_bus_valid !== 1'b0) begin errors++; $display("FAIL single_c0_valid: got %b want 0", o_bus_valid); end
        step();
        checks++; if (o_bus_valid !== 1'b1 || o_bus_address !== 8'h10 || o_bus_write !== 1'b0)
            begin errors++; $display("FAIL single_c1_cmd: got %b/%h/%b want 1/10/0", o_bus_valid, o_bus_address, o_bus_write); end
        checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL single_c1_ready: got %b want 000", o_ready); end
        step();
        checks++; if (o_bus_valid !== 1'b1 || o_ready !== 3'b000)
            begin errors++; $display("FAIL single_c2: got %b/%b want 1/000", o_bus_valid, o_ready); end
        step();
        i_bus_ready = 1'b1;
        i_bus_read_data = 32'hDEADBEEF;
        #1;
        checks++; if (o_ready !== 3'b001) begin errors++; $display("FAIL single_c3_ready: got %b want 001", o_ready); end
        checks++; if (o_read_data !== 32'hDEADBEEF || o_status !== 2'b00)
            begin errors++; $display("FAIL single_c3_data: got %h/%b want deadbeef/00", o_read_data, o_status); end
        step();
        i_request = '0;
        #1;
        checks++; if (o_bus_valid !== 1'b0 || o_ready !== 3'b000 || o_read_data !== 32'h0)
            begin errors++; $display("FAIL single_c4_idle: got %b/%b/%h want 0/000/0", o_bus_valid, o_ready, o_read_data); end
        i_bus_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_order [6];
        logic [N-1:0] got [6];
        int n = 0;
        int idle_ready_bad = 0;
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        apply_reset();
        i_request = 3'b111;
        i_bus_ready = 1'b1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            step();
            if (!o_bus_valid && o_ready !== 3'b000) idle_ready_bad++;
            if (o_ready !== 3'b000) begin
                got[n] = o_ready;
                n++;
            end
        end
        i_request = '0;
        i_bus_ready = 1'b0;
        checks++; if (n !== 6) begin errors++; $display("FAIL rr_count: got %0d want 6", n); end
        for (int k = 0; k < 6 && k < n; k++) begin
            checks++; if (got[k] !== exp_order[k])
                begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", k, got[k], exp_order[k]); end
        end
        checks++; if (idle_ready_bad !== 0) begin errors++; $display("FAIL rr_idle_ready: got %0d want 0", idle_ready_bad); end
        step();
    endtask

    task automatic test_contention();
        apply_reset();
        i_request = 3'b011;
        i_address = {8'h00, 8'h30, 8'h20};
        i_write = 3'b011;
        i_write_data = {32'h0, 32'h22222222, 32'h11111111};
        step();
        checks++; if (o_bus_address !== 8'h20 || o_bus_write !== 1'b1 || o_bus_write_data !== 32'h11111111)
            begin errors++; $display("FAIL cont_first: got %h/%b/%h want 20/1/11111111", o_bus_address, o_bus_write, o_bus_write_data); end
        step();
        checks++; if (o_ready !== 3'b000) begin errors++; $display("FAIL cont_wait: got %b want 000", o_ready); end
        i_bus_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 3'b001) begin errors++; $display("FAIL cont_done0: got %b want 001", o_ready); end
        step();
        i_request = 3'b010;
        i_bus_ready = 1'b0;
        #1;
        checks++; if (o_bus_valid !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b want 0", o_bus_valid); end
        step();
        checks++; if (o_bus_valid !== 1'b1 || o_bus_address !== 8'h30 || o_bus_write_data !== 32'h22222222)
            begin errors++; $display("FAIL cont_second: got %b/%h/%h want 1/30/22222222", o_bus_valid, o_bus_address, o_bus_write_data); end
        i_bus_ready = 1'b1;
        #1;
        checks++; if (o_ready !== 3'b010) begin errors++; $display("FAIL cont_done1: got %b want 010", o_ready); end
        step();
        i_request = '0;
        i_bus_ready = 1'b0;
    endtask

    task automatic test_error_response();
        apply_reset();
        i_request = 3'b100;
        step();
        i_bus_ready = 1'b1;
        i_bus_status = 2'b01;
        i_bus_read_data = 32'h0BADF00D;
        #1;
        checks++; if (o_status !== 2'b01 || o_ready !== 3'b100)
            begin errors++; $display("FAIL err_ready: got %b/%b want 01/100", o_status, o_ready); end
        step();
        i_request = '0;
        i_bus_ready = 1'b0;
        #1;
        checks++; if (o_status !== 2'b00 || o_read_data !== 32'h0)
            begin errors++; $display("FAIL err_after: got %b/%h want 00/0", o_status, o_read_data); end
        i_bus_status = 2'b00;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_request = 3'b001;
        step();
        checks++; if (o_bus_valid !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", o_bus_valid); end
        i_rst = 1'b1;
        step();
        i_bus_ready = 1'b1;
        #1;
        checks++; if (o_bus_valid !== 1'b0 || o_ready !== 3'b000)
            begin errors++; $display("FAIL mid_reset: got %b/%b want 0/000", o_bus_valid, o_ready); end
        i_rst = 1'b0;
        i_bus_ready = 1'b0;
        i_request = 3'b010;
        step();
        i_bus_ready = 1'b1;
        #1;
        checks++; if (o_bus_valid !== 1'b1 || o_ready !== 3'b010)
            begin errors++; $display("FAIL mid_regrant: got %b/%b want 1/010", o_bus_valid, o_ready); end
        step();
        i_request = '0;
        i_bus_ready = 1'b0;
    endtask

`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        apply_reset();
        i_request = 3'b001;
        i_bus_read_data = 32'h12345678;
        i_bus_status = 2'b01;
        for (int c = 1; c <= TO; c++) begin
            step();
            if (o_ready !== 3'b000) early++;
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d want 0", early); end
        step();
        checks++; if (o_ready !== 3'b001 || o_status !== 2'b10 || o_read_data !== 32'h0)
            begin errors++; $display("FAIL to_pulse: got %b/%b/%h want 001/10/0", o_ready, o_status, o_read_data); end
        i_request = '0;
        step();
        checks++; if (o_bus_valid !== 1'b0) begin errors++; $display("FAIL to_idle: got %b want 0", o_bus_valid); end
        i_bus_status = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_contention();
        test_error_response();
        test_reset_mid();
`ifdef RGGEN_BUS_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rggen_bus_arbiter.md
Name: rggen_bus_arbiter

Overview:
- Round-robin arbiter that shares one downstream register-bus port between REQUESTERS upstream masters.
- Grants exactly one requester at a time and holds the grant for the full transaction.
- Forwards the granted requester's command to the register block, and returns the response plus a one-cycle ready pulse to that requester only.
- Sits between host-interface bridges and the generated register block.

Parameters:
- REQUESTERS, 2, number of upstream masters; must be ≥ 1.
- ADDRESS_WIDTH, 8, bus address width.
- DATA_WIDTH, 32, bus data width.
- TIMEOUT_CYCLES, 256, BUSY-cycle limit; used only when the timeout feature is compiled in; must be ≥ 1.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_request  input  REQUESTERS  per-requester transaction request.
- i_address  input  REQUESTERS*ADDRESS_WIDTH  packed addresses; entry k is at [k*ADDRESS_WIDTH+:ADDRESS_WIDTH].
- i_write  input  REQUESTERS  1 = write, 0 = read.
- i_write_data  input  REQUESTERS*DATA_WIDTH  packed write data.
- o_ready  output  REQUESTERS  one-hot completion pulse.
- o_read_data  output  DATA_WIDTH  response data, broadcast to all requesters.
- o_status  output  2  response status, broadcast: 00 OK, 01 slave error, 10 timeout.
- o_bus_valid  output  1  downstream command valid.
- o_bus_address  output  ADDRESS_WIDTH  downstream address.
- o_bus_write  output  1  downstream write flag.
- o_bus_write_data  output  DATA_WIDTH  downstream write data.
- i_bus_ready  input  1  downstream completion.
- i_bus_read_data  input  DATA_WIDTH  downstream read data.
- i_bus_status  input  2  downstream status.

Behaviour:
- Clock and reset: one clock (i_clk); reset (i_rst) is synchronous and active-high.
- State machine: two states, IDLE and BUSY.
  - Registers: grant (one-hot, REQUESTERS bits) and last_grant index.
  - Reset values: state=IDLE, grant=0, last_grant=REQUESTERS-1, so requester 0 has top priority after reset.
  - Output reset values: o_bus_valid=0, o_ready=0; o_bus_address, o_bus_write, o_bus_write_data, o_read_data and o_status all 0.
- IDLE:
  - If i_request != 0, pick the first requesting index after last_grant, searching circularly upward.
  - Register that index as grant; go to BUSY.
  - Otherwise stay in IDLE with grant=0.
- BUSY:
  - o_bus_valid=1.
  - Bus payload = one-hot-masked OR of the granted entry.
  - When grant=0 the payload is all zeros.
- Completion (i_bus_ready=1 in BUSY):
  - o_ready = grant, combinational, for that cycle only.
  - o_read_data = i_bus_read_data and o_status = i_bus_status in the same cycle.
  - Next cycle: state=IDLE, last_grant=granted index, grant=0.
- Latency:
  - Request sampled at cycle 0 → o_bus_valid at cycle 1.
  - Minimum 3 cycles from request to next grant, because IDLE always spends at least one cycle.
  - A requester holding i_request continuously gets at most one transaction per arbitration round when others are requesting.
- Outside completion cycles: o_ready=0; o_read_data and o_status are 0.
- Requester rules:
  - A requester holds i_request and its payload stable until its o_ready pulse.
  - Deasserting i_request while granted is ignored; the transaction completes normally.
- i_bus_ready in IDLE is ignored.
- A single requester requesting every IDLE is granted back-to-back.
- REQUESTERS=1: the arbiter degenerates to a pass-through plus the IDLE/BUSY sequencing.
- Reset asserted mid-transaction: next edge returns to the reset state; no o_ready pulse is issued.

Optional Feature:
- Macro: RGGEN_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - Adds a counter of $clog2(TIMEOUT_CYCLES+1) bits; it clears on entering BUSY and increments each BUSY cycle without i_bus_ready.
  - When the count reaches TIMEOUT_CYCLES without i_bus_ready: pulse o_ready=grant with o_status=10 and o_read_data=0, then return to IDLE.
  - If i_bus_ready arrives in that same cycle, the real response wins.
- Undefined: no counter exists; BUSY waits indefinitely.

Decomposition:
- Shared header file holds:
  - state encodings for IDLE and BUSY;
  - status constants: OK=2'b00, SLVERR=2'b01, TIMEOUT=2'b10.
- Sub-module rggen_rr_picker (combinational):
  - Inputs: request vector and last_grant.
  - Output: one-hot next grant.
  - Implemented as a double-width rotated priority search.
- Payload selection reuses the team's existing one-hot mux, rggen_mux, instantiated three times (address, write flag, write data).

Test Plan:
- Single request: REQUESTERS=2, i_request=01, addr0=0x10, write read, i_bus_ready two cycles after valid with data 0xDEADBEEF → o_bus_valid at cycle 1; o_ready=01 at cycle 3 with o_read_data=0xDEADBEEF; IDLE at cycle 4.
- Round-robin: REQUESTERS=3, all requests held for 6 transactions, ready immediate → grant order 0,1,2,0,1,2.
- Contention after reset: i_request=11 in the first cycle after reset → requester 0 granted first; requester 1 waits with o_ready[1]=0 until requester 0 completes.
- Error response: i_bus_status=01 on completion → o_status=01 only in the ready cycle, then 00.
- Reset mid-transaction: i_rst asserted in BUSY → next cycle o_bus_valid=0 and o_ready=0; after release with i_request=10, requester 1 is granted.
- Timeout (macro defined, TIMEOUT_CYCLES=4): i_bus_ready held 0 → o_ready pulse with o_status=10 and o_read_data=0 after 4 BUSY cycles.
